// File: rtl/rvfi_commit_tracker_if.sv
// Event inputs from the OoO core and the RVFI commit stream toward the monitor.
// The master side is the core/ROB. The slave side is the tracker.
interface rvfi_commit_tracker_if #(
  parameter int TAG_W = 4
);
  logic             dis_valid;
  logic [TAG_W-1:0] dis_tag;
  logic [31:0]      dis_pc;
  logic [31:0]      dis_pc_next;
  logic [31:0]      dis_inst;
  logic [4:0]       dis_rs1;
  logic [4:0]       dis_rs2;
  logic [4:0]       dis_rd;

  logic             iss_valid;
  logic [TAG_W-1:0] iss_tag;
  logic [31:0]      iss_rs1_rdata;
  logic [31:0]      iss_rs2_rdata;

  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_rd_wdata;
  logic [31:0]      wb_pc_wdata;

  logic             mem_valid;
  logic [TAG_W-1:0] mem_tag;
  logic [31:0]      mem_addr;
  logic [3:0]       mem_rmask;
  logic [3:0]       mem_wmask;
  logic [31:0]      mem_rdata;
  logic [31:0]      mem_wdata;

  logic             commit_valid;
  logic [TAG_W-1:0] commit_tag;
  logic             flush;

  logic             rvfi_valid;
  logic [63:0]      rvfi_order;
  logic [31:0]      rvfi_inst;
  logic [31:0]      rvfi_pc_rdata;
  logic [31:0]      rvfi_pc_wdata;
  logic [4:0]       rvfi_rs1_addr;
  logic [4:0]       rvfi_rs2_addr;
  logic [4:0]       rvfi_rd_addr;
  logic [31:0]      rvfi_rs1_rdata;
  logic [31:0]      rvfi_rs2_rdata;
  logic [31:0]      rvfi_rd_wdata;
  logic [31:0]      rvfi_mem_addr;
  logic [3:0]       rvfi_mem_rmask;
  logic [3:0]       rvfi_mem_wmask;
  logic [31:0]      rvfi_mem_rdata;
  logic [31:0]      rvfi_mem_wdata;
  logic             proto_err;

  modport master (
    output dis_valid, dis_tag, dis_pc, dis_pc_next, dis_inst, dis_rs1, dis_rs2, dis_rd,
    output iss_valid, iss_tag, iss_rs1_rdata, iss_rs2_rdata,
    output wb_valid, wb_tag, wb_rd_wdata, wb_pc_wdata,
    output mem_valid, mem_tag, mem_addr, mem_rmask, mem_wmask, mem_rdata, mem_wdata,
    output commit_valid, commit_tag, flush,
    input  rvfi_valid, rvfi_order, rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata,
    input  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr, rvfi_rs1_rdata, rvfi_rs2_rdata,
    input  rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
    input  rvfi_mem_rdata, rvfi_mem_wdata, proto_err
  );

  modport slave (
    input  dis_valid, dis_tag, dis_pc, dis_pc_next, dis_inst, dis_rs1, dis_rs2, dis_rd,
    input  iss_valid, iss_tag, iss_rs1_rdata, iss_rs2_rdata,
    input  wb_valid, wb_tag, wb_rd_wdata, wb_pc_wdata,
    input  mem_valid, mem_tag, mem_addr, mem_rmask, mem_wmask, mem_rdata, mem_wdata,
    input  commit_valid, commit_tag, flush,
    output rvfi_valid, rvfi_order, rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata,
    output rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr, rvfi_rs1_rdata, rvfi_rs2_rdata,
    output rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
    output rvfi_mem_rdata, rvfi_mem_wdata, proto_err
  );
endinterface

// File: rtl/rvfi_commit_tracker.sv
// RVFI producer: shadows each ROB entry with a record filled by dispatch/issue/
// writeback/memory events and emits it in program order on commit.
module rvfi_commit_tracker #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
  input logic                clk,
  input logic                rst,
  rvfi_commit_tracker_if.slave bus
);

  typedef struct packed {
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] inst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } record_t;

  record_t                entries [ROB_DEPTH];
  logic [ROB_DEPTH-1:0]   entry_valid;
  logic [ROB_DEPTH-1:0]   valid_next;
  logic [63:0]            commit_count;

  record_t                dis_rec;
  record_t                merged;
  record_t                emit;
  record_t                out_rec;
  logic                   out_valid;
  logic [63:0]            out_order;
  logic                   err_q;

  logic hit_iss, hit_wb, hit_mem, err_now;

  function automatic logic [31:0] keep_bytes(input logic [31:0] data, input logic [3:0] mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = mask[b] ? data[8*b +: 8] : 8'h00;
    return res;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    dis_rec           = '0;
    dis_rec.pc_rdata  = bus.dis_pc;
    dis_rec.pc_wdata  = bus.dis_pc_next;
    dis_rec.inst      = bus.dis_inst;
    dis_rec.rs1_addr  = bus.dis_rs1;
    dis_rec.rs2_addr  = bus.dis_rs2;
    dis_rec.rd_addr   = bus.dis_rd;

    hit_iss = bus.iss_valid && entry_valid[bus.iss_tag];
    hit_wb  = bus.wb_valid  && entry_valid[bus.wb_tag];
    hit_mem = bus.mem_valid && entry_valid[bus.mem_tag];

    // Updates on a free slot, or racing a dispatch to the same slot, are protocol errors.
    err_now = (bus.iss_valid && (!entry_valid[bus.iss_tag] ||
                                 (bus.dis_valid && bus.dis_tag == bus.iss_tag)))
           || (bus.wb_valid  && (!entry_valid[bus.wb_tag] ||
                                 (bus.dis_valid && bus.dis_tag == bus.wb_tag)))
           || (bus.mem_valid && (!entry_valid[bus.mem_tag] ||
                                 (bus.dis_valid && bus.dis_tag == bus.mem_tag)))
           || (bus.commit_valid && !entry_valid[bus.commit_tag]);

    // Record leaving this cycle, with same-cycle updates folded in.
    merged = entry_valid[bus.commit_tag] ? entries[bus.commit_tag] : '0;
    if (hit_iss && bus.iss_tag == bus.commit_tag) begin
      merged.rs1_rdata = bus.iss_rs1_rdata;
      merged.rs2_rdata = bus.iss_rs2_rdata;
    end
    if (hit_wb && bus.wb_tag == bus.commit_tag) begin
      merged.rd_wdata = bus.wb_rd_wdata;
      merged.pc_wdata = bus.wb_pc_wdata;
    end
    if (hit_mem && bus.mem_tag == bus.commit_tag) begin
      merged.mem_addr  = bus.mem_addr;
      merged.mem_rmask = bus.mem_rmask;
      merged.mem_wmask = bus.mem_wmask;
      merged.mem_rdata = bus.mem_rdata;
      merged.mem_wdata = bus.mem_wdata;
    end

    emit = merged;
    if (merged.rs1_addr == 5'd0) emit.rs1_rdata = '0;
    if (merged.rs2_addr == 5'd0) emit.rs2_rdata = '0;
    if (merged.rd_addr  == 5'd0) emit.rd_wdata  = '0;
    emit.mem_addr  = {merged.mem_addr[31:2], 2'b00};
    emit.mem_rdata = keep_bytes(merged.mem_rdata, merged.mem_rmask);
    emit.mem_wdata = keep_bytes(merged.mem_wdata, merged.mem_wmask);

    valid_next = entry_valid;
    if (bus.commit_valid) valid_next[bus.commit_tag] = 1'b0;
    if (bus.dis_valid)    valid_next[bus.dis_tag]    = 1'b1;
    if (bus.flush)        valid_next = '0;
  end

  // NOTE: the record storage has no reset; entry_valid alone says whether a slot holds data.
  always_ff @(posedge clk) begin
    if (hit_iss) begin
      entries[bus.iss_tag].rs1_rdata <= bus.iss_rs1_rdata;
      entries[bus.iss_tag].rs2_rdata <= bus.iss_rs2_rdata;
    end
    if (hit_wb) begin
      entries[bus.wb_tag].rd_wdata <= bus.wb_rd_wdata;
      entries[bus.wb_tag].pc_wdata <= bus.wb_pc_wdata;
    end
    if (hit_mem) begin
      entries[bus.mem_tag].mem_addr  <= bus.mem_addr;
      entries[bus.mem_tag].mem_rmask <= bus.mem_rmask;
      entries[bus.mem_tag].mem_wmask <= bus.mem_wmask;
      entries[bus.mem_tag].mem_rdata <= bus.mem_rdata;
      entries[bus.mem_tag].mem_wdata <= bus.mem_wdata;
    end
    // Placed last so a colliding dispatch overwrites the whole record.
    if (bus.dis_valid) entries[bus.dis_tag] <= dis_rec;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_valid  <= '0;
      commit_count <= '0;
      out_valid    <= 1'b0;
      out_order    <= '0;
      out_rec      <= '0;
      err_q        <= 1'b0;
    end else begin
      entry_valid <= valid_next;
      out_valid   <= bus.commit_valid;
      if (bus.commit_valid) begin
        out_rec      <= emit;
        out_order    <= commit_count;
        commit_count <= commit_count + 64'd1;
      end
      if (err_now) err_q <= 1'b1;
    end
  end

  assign bus.rvfi_valid     = out_valid;
  assign bus.rvfi_order     = out_order;
  assign bus.rvfi_inst      = out_rec.inst;
  assign bus.rvfi_pc_rdata  = out_rec.pc_rdata;
  assign bus.rvfi_pc_wdata  = out_rec.pc_wdata;
  assign bus.rvfi_rs1_addr  = out_rec.rs1_addr;
  assign bus.rvfi_rs2_addr  = out_rec.rs2_addr;
  assign bus.rvfi_rd_addr   = out_rec.rd_addr;
  assign bus.rvfi_rs1_rdata = out_rec.rs1_rdata;
  assign bus.rvfi_rs2_rdata = out_rec.rs2_rdata;
  assign bus.rvfi_rd_wdata  = out_rec.rd_wdata;
  assign bus.rvfi_mem_addr  = out_rec.mem_addr;
  assign bus.rvfi_mem_rmask = out_rec.mem_rmask;
  assign bus.rvfi_mem_wmask = out_rec.mem_wmask;
  assign bus.rvfi_mem_rdata = out_rec.mem_rdata;
  assign bus.rvfi_mem_wdata = out_rec.mem_wdata;
  assign bus.proto_err      = err_q;

endmodule
